// File: rtl/car_dash_pkg.sv
// Shared types for the dashboard button front end: debounce FSM states and
// the 2-bit button codes driven onto the button bus.
package car_dash_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } db_state_e;

    localparam logic [1:0] BTN_NONE = 2'b00;
    localparam logic [1:0] BTN_0    = 2'b01;
    localparam logic [1:0] BTN_1    = 2'b10;

    // Both buttons down is not a legal code; it collapses to BTN_NONE.
    function automatic logic [1:0] encode_buttons(input logic [1:0] level);
        logic [1:0] code;
        code = BTN_NONE;
        case (level)
            2'b01:   code = BTN_0;
            2'b10:   code = BTN_1;
            default: code = BTN_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bus between the board pins, the conditioner and the menu logic.
// master: pin/stimulus side driving btn_raw; slave: the conditioner.
interface button_conditioner_if;

    logic [1:0] btn_raw;
    logic [1:0] Buttons;
    logic [1:0] press_pulse;
    logic       both_held;

    modport master (
        output btn_raw,
        input  Buttons,
        input  press_pulse,
        input  both_held
    );

    modport slave (
        input  btn_raw,
        output Buttons,
        output press_pulse,
        output both_held
    );

endinterface

// File: rtl/button_debounce.sv
// One button: synchroniser, debounce FSM with saturating counter and, when
// AUTOREPEAT_EN is defined, the hold/auto-repeat counter.
module button_debounce
    import car_dash_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
`ifdef AUTOREPEAT_EN
    input  logic hold_clr_i,
`endif
    output logic level_o,
    output logic press_o
);

    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("button_debounce: SYNC_STAGES>=2 and nonzero cycle counts required");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    db_state_e              state_q;
    logic [DEB_W-1:0]       cnt_q;
    logic                   acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw_i};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // The count includes the sample that left IDLE/PRESSED, so a run of
    // DEBOUNCE_CYCLES stable samples is exactly what gets accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
        end else begin
            acc_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (sync) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_q <= PRESSED;
                            acc_q   <= 1'b1;
                        end else begin
                            state_q <= PRESS_WAIT;
                            cnt_q   <= DEB_W'(1);
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!sync) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= PRESSED;
                        acc_q   <= 1'b1;
                        cnt_q   <= '0;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    cnt_q <= '0;
                    if (!sync) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= RELEASE_WAIT;
                            cnt_q   <= DEB_W'(1);
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (sync) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level_o = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

`ifdef AUTOREPEAT_EN
    localparam int unsigned HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt_q;
    logic              rep_phase_q;
    logic              rep_q;

    // First strobe after HOLD_CYCLES in PRESSED, then one per REPEAT_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q  <= '0;
            rep_phase_q <= 1'b0;
            rep_q       <= 1'b0;
        end else begin
            rep_q <= 1'b0;
            if (state_q != PRESSED || hold_clr_i) begin
                hold_cnt_q  <= '0;
                rep_phase_q <= 1'b0;
            end else if (!rep_phase_q && hold_cnt_q == HOLD_LAST) begin
                rep_q       <= 1'b1;
                rep_phase_q <= 1'b1;
                hold_cnt_q  <= '0;
            end else if (rep_phase_q && hold_cnt_q == REP_LAST) begin
                rep_q      <= 1'b1;
                hold_cnt_q <= '0;
            end else if (hold_cnt_q != '1) begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end
        end
    end

    assign press_o = acc_q | rep_q;
`else
    assign press_o = acc_q;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Dashboard 2-bit button front end: two debouncers, level encoding, strobe
// suppression and output registers. Optional auto-repeat via AUTOREPEAT_EN.
module button_conditioner
    import car_dash_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 10000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    button_conditioner_if.slave  btn_bus
);

    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] buttons_q;
    logic [1:0] press_pulse_q;
    logic       both_held_q;

    button_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_db0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw_i  (btn_bus.btn_raw[0]),
`ifdef AUTOREPEAT_EN
        .hold_clr_i (level[1]),
`endif
        .level_o    (level[0]),
        .press_o    (press[0])
    );

    button_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_db1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw_i  (btn_bus.btn_raw[1]),
`ifdef AUTOREPEAT_EN
        .hold_clr_i (level[0]),
`endif
        .level_o    (level[1]),
        .press_o    (press[1])
    );

    // The other bit's post-edge level also covers both entering PRESSED together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buttons_q     <= BTN_NONE;
            press_pulse_q <= '0;
            both_held_q   <= 1'b0;
        end else begin
            buttons_q        <= encode_buttons(level);
            both_held_q      <= &level;
            press_pulse_q[0] <= press[0] & ~level[1];
            press_pulse_q[1] <= press[1] & ~level[0];
        end
    end

    assign btn_bus.Buttons     = buttons_q;
    assign btn_bus.press_pulse = press_pulse_q;
    assign btn_bus.both_held   = both_held_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE=8, HOLD=32, REPEAT=8.
// Expectations for the repeat scenario depend on AUTOREPEAT_EN.
module tb_button_conditioner;

    import car_dash_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    button_conditioner_if bus();

    button_conditioner #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8),
        .HOLD_CYCLES     (32),
        .REPEAT_CYCLES   (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        bus.btn_raw = 2'b00;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.btn_raw = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if ({bus.Buttons, bus.press_pulse, bus.both_held} !== 5'b00000) begin
                failures++;
                $display("FAIL reset cyc%0d: Buttons=%b press=%b both=%b required 00/00/0",
                         k, bus.Buttons, bus.press_pulse, bus.both_held);
            end
        end
        bus.btn_raw = 2'b00;
        rst_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            checks++;
            if ({bus.Buttons, bus.press_pulse, bus.both_held} !== 5'b00000) begin
                failures++;
                $display("FAIL post_reset cyc%0d: Buttons=%b press=%b both=%b required 00/00/0",
                         k, bus.Buttons, bus.press_pulse, bus.both_held);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [1:0] eb, ep;
        bus.btn_raw = 2'b01;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (k <= 20) eb = (k >= 11) ? BTN_0 : BTN_NONE;
            else         eb = (k < 31)  ? BTN_0 : BTN_NONE;
            ep = (k == 11) ? 2'b01 : 2'b00;
            checks++;
            if ({bus.Buttons, bus.press_pulse, bus.both_held} !== {eb, ep, 1'b0}) begin
                failures++;
                $display("FAIL clean_press cyc%0d: Buttons=%b press=%b both=%b required %b/%b/0",
                         k, bus.Buttons, bus.press_pulse, bus.both_held, eb, ep);
            end
            if (k == 20) bus.btn_raw = 2'b00;
        end
    endtask

    task automatic test_glitch_boundary();
        logic [1:0] eb, ep;
        // 7-cycle pulse: one sample short, must be ignored
        bus.btn_raw = 2'b01;
        for (int k = 1; k <= 30; k++) begin
            tick();
            checks++;
            if ({bus.Buttons, bus.press_pulse} !== 4'b0000) begin
                failures++;
                $display("FAIL glitch7 cyc%0d: Buttons=%b press=%b required 00/00",
                         k, bus.Buttons, bus.press_pulse);
            end
            if (k == 7) bus.btn_raw = 2'b00;
        end
        // 8-cycle pulse: exactly long enough to be accepted
        bus.btn_raw = 2'b01;
        for (int k = 1; k <= 30; k++) begin
            tick();
            eb = (k >= 11 && k < 19) ? BTN_0 : BTN_NONE;
            ep = (k == 11) ? 2'b01 : 2'b00;
            checks++;
            if ({bus.Buttons, bus.press_pulse} !== {eb, ep}) begin
                failures++;
                $display("FAIL glitch8 cyc%0d: Buttons=%b press=%b required %b/%b",
                         k, bus.Buttons, bus.press_pulse, eb, ep);
            end
            if (k == 8) bus.btn_raw = 2'b00;
        end
    endtask

    task automatic test_bounce();
        logic [1:0] eb, ep;
        bus.btn_raw = 2'b10;
        for (int k = 1; k <= 60; k++) begin
            tick();
            eb = (k >= 41) ? BTN_1 : BTN_NONE;
            ep = (k == 41) ? 2'b10 : 2'b00;
            checks++;
            if ({bus.Buttons, bus.press_pulse, bus.both_held} !== {eb, ep, 1'b0}) begin
                failures++;
                $display("FAIL bounce cyc%0d: Buttons=%b press=%b both=%b required %b/%b/0",
                         k, bus.Buttons, bus.press_pulse, bus.both_held, eb, ep);
            end
            if (k < 30) bus.btn_raw = (((k / 3) % 2) == 0) ? 2'b10 : 2'b00;
            else        bus.btn_raw = 2'b10;
        end
        settle(25);
        checks++;
        if (bus.Buttons !== BTN_NONE) begin
            failures++;
            $display("FAIL bounce_release: Buttons=%b required 00", bus.Buttons);
        end
    endtask

    task automatic test_both_pressed();
        logic [1:0] eb, ep;
        logic       eh;
        bus.btn_raw = 2'b01;
        for (int k = 1; k <= 70; k++) begin
            tick();
            eb = (k >= 11 && k < 31) ? BTN_0 : BTN_NONE;
            ep = (k == 11) ? 2'b01 : 2'b00;
            eh = (k >= 31 && k < 61);
            checks++;
            if ({bus.Buttons, bus.press_pulse, bus.both_held} !== {eb, ep, eh}) begin
                failures++;
                $display("FAIL both_seq cyc%0d: Buttons=%b press=%b both=%b required %b/%b/%b",
                         k, bus.Buttons, bus.press_pulse, bus.both_held, eb, ep, eh);
            end
            if (k == 20) bus.btn_raw = 2'b11;
            if (k == 50) bus.btn_raw = 2'b00;
        end
        settle(10);
        bus.btn_raw = 2'b11;
        for (int k = 1; k <= 20; k++) begin
            tick();
            eh = (k >= 11);
            checks++;
            if ({bus.Buttons, bus.press_pulse, bus.both_held} !== {4'b0000, eh}) begin
                failures++;
                $display("FAIL both_simul cyc%0d: Buttons=%b press=%b both=%b required 00/00/%b",
                         k, bus.Buttons, bus.press_pulse, bus.both_held, eh);
            end
        end
        settle(25);
    endtask

    task automatic test_reset_mid_debounce();
        logic [1:0] eb, ep;
        bus.btn_raw = 2'b01;
        for (int k = 1; k <= 4; k++) tick();
        rst_n = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if ({bus.Buttons, bus.press_pulse, bus.both_held} !== 5'b00000) begin
                failures++;
                $display("FAIL mid_reset_hold cyc%0d: Buttons=%b press=%b both=%b required 00/00/0",
                         k, bus.Buttons, bus.press_pulse, bus.both_held);
            end
        end
        rst_n = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            tick();
            eb = (j >= 11) ? BTN_0 : BTN_NONE;
            ep = (j == 11) ? 2'b01 : 2'b00;
            checks++;
            if ({bus.Buttons, bus.press_pulse} !== {eb, ep}) begin
                failures++;
                $display("FAIL mid_reset_restart cyc%0d: Buttons=%b press=%b required %b/%b",
                         j, bus.Buttons, bus.press_pulse, eb, ep);
            end
        end
        settle(25);
    endtask

    task automatic test_autorepeat();
        logic [1:0] eb, ep;
        logic       pulse;
        bus.btn_raw = 2'b01;
        for (int k = 1; k <= 100; k++) begin
            tick();
`ifdef AUTOREPEAT_EN
            pulse = (k == 11) || (k >= 43 && k <= 83 && ((k - 43) % 8) == 0);
`else
            pulse = (k == 11);
`endif
            ep = pulse ? 2'b01 : 2'b00;
            eb = (k >= 11 && k < 91) ? BTN_0 : BTN_NONE;
            checks++;
            if ({bus.Buttons, bus.press_pulse} !== {eb, ep}) begin
                failures++;
                $display("FAIL repeat cyc%0d: Buttons=%b press=%b required %b/%b",
                         k, bus.Buttons, bus.press_pulse, eb, ep);
            end
            if (k == 80) bus.btn_raw = 2'b00;
        end
    endtask

    initial begin
        bus.btn_raw = 2'b11;
        test_reset();
        test_clean_press();
        test_glitch_boundary();
        test_bounce();
        test_both_pressed();
        test_reset_mid_debounce();
        test_autorepeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
